// File: rtl/niu32_mmio_responder.sv
// Niu32 MMIO responder: HEX/LED output registers, debounced KEY,
// sticky key-press flags and synchronized SWITCH behind a one-cycle ack.
module niu32_mmio_responder #(
    parameter int          WORD_SIZE       = 32,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] ADDR_HEX        = 32'hFFFF0000,
    parameter logic [31:0] ADDR_LEDR       = 32'hFFFF0020,
    parameter logic [31:0] ADDR_LEDG       = 32'hFFFF0040,
    parameter logic [31:0] ADDR_KEY        = 32'hFFFF0100,
    parameter logic [31:0] ADDR_KEYEDGE    = 32'hFFFF0104,
    parameter logic [31:0] ADDR_SWITCH     = 32'hFFFF0120
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic                 hit,
    output logic                 ack,
    output logic [WORD_SIZE-1:0] rdata,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SWITCH,
    output logic [15:0]          HEX_VAL,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RESP = 1'b1;

    logic                 state;
    logic                 accept;
    logic                 sel_hex, sel_ledr, sel_ledg;
    logic                 sel_key, sel_kedge, sel_sw;
    logic [WORD_SIZE-1:0] rd_mux;
    logic [3:0]           key_s1, key_s2, key_db, db_next;
    logic [3:0][15:0]     cnt, cnt_next;
    logic [3:0]           key_edge, fall, kedge_clr;
    logic [9:0]           sw_s1, sw_s2;
    logic                 unused_wdata;

    assign unused_wdata = ^wdata[WORD_SIZE-1:16];

    assign hit    = (addr[31:12] == 20'hFFFF0);
    assign accept = req & hit & (state == S_IDLE);
    assign ack    = (state == S_RESP);

    assign sel_hex   = (addr == ADDR_HEX);
    assign sel_ledr  = (addr == ADDR_LEDR);
    assign sel_ledg  = (addr == ADDR_LEDG);
    assign sel_key   = (addr == ADDR_KEY);
    assign sel_kedge = (addr == ADDR_KEYEDGE);
    assign sel_sw    = (addr == ADDR_SWITCH);

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_hex:   rd_mux = WORD_SIZE'(HEX_VAL);
            sel_ledr:  rd_mux = WORD_SIZE'(LEDR);
            sel_ledg:  rd_mux = WORD_SIZE'(LEDG);
            sel_key:   rd_mux = WORD_SIZE'(key_db);
            sel_kedge: rd_mux = WORD_SIZE'(key_edge);
            sel_sw:    rd_mux = WORD_SIZE'(sw_s2);
            default:   rd_mux = '0;
        endcase
    end

    // A bit's counter only runs while its synchronized level disagrees
    // with the debounced level; any agreement (a bounce) restarts it.
    always_comb begin
        db_next  = key_db;
        cnt_next = cnt;
        for (int i = 0; i < 4; i++) begin
            if (key_s2[i] == key_db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] + 16'd1 == DEBOUNCE_CYCLES) begin
                db_next[i]  = key_s2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + 16'd1;
            end
        end
    end

    assign fall      = key_db & ~db_next;
    assign kedge_clr = (accept & we & sel_kedge) ? wdata[3:0] : 4'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            key_db   <= 4'hF;
            cnt      <= '0;
            key_edge <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            key_db   <= db_next;
            cnt      <= cnt_next;
            key_edge <= (key_edge & ~kedge_clr) | fall;
            sw_s1    <= SWITCH;
            sw_s2    <= sw_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            rdata   <= '0;
            HEX_VAL <= '0;
            LEDR    <= '0;
            LEDG    <= '0;
        end else begin
            state <= accept ? S_RESP : S_IDLE;
            rdata <= accept ? rd_mux : '0;
            if (accept && we) begin
                if (sel_hex)  HEX_VAL <= wdata[15:0];
                if (sel_ledr) LEDR    <= wdata[9:0];
                if (sel_ledg) LEDG    <= wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_niu32_mmio_responder.sv
// Randomized and directed bench for niu32_mmio_responder against
// a register-map reference model.
module tb_niu32_mmio_responder;

    localparam logic [31:0] A_HEX   = 32'hFFFF0000;
    localparam logic [31:0] A_LEDR  = 32'hFFFF0020;
    localparam logic [31:0] A_LEDG  = 32'hFFFF0040;
    localparam logic [31:0] A_KEY   = 32'hFFFF0100;
    localparam logic [31:0] A_KEDGE = 32'hFFFF0104;
    localparam logic [31:0] A_SW    = 32'hFFFF0120;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        hit, ack;
    logic [31:0] rdata;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SWITCH = '0;
    logic [15:0] HEX_VAL;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_hex  = '0;
    logic [9:0]  m_ledr = '0;
    logic [7:0]  m_ledg = '0;

    niu32_mmio_responder #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .hit(hit), .ack(ack),
        .rdata(rdata), .KEY(KEY), .SWITCH(SWITCH),
        .HEX_VAL(HEX_VAL), .LEDR(LEDR), .LEDG(LEDG)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Request in the current cycle N; returns ack/rdata seen in N+1
    // and in N+2, and leaves the bench in cycle N+2.
    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d,
                          output logic ak1, output logic [31:0] rd1,
                          output logic ak2, output logic [31:0] rd2);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick(1);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ak1 = ack; rd1 = rdata;
        tick(1);
        ak2 = ack; rd2 = rdata;
    endtask

    task automatic test_reset;
        logic a1, a2;
        logic [31:0] r1, r2;
        reset_n = 1'b0;
        tick(3);
        n_tests++;
        if ({ack, rdata, HEX_VAL, LEDR, LEDG} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b rdata=%h hex=%h ledr=%h ledg=%h required all 0",
                     ack, rdata, HEX_VAL, LEDR, LEDG);
        end
        reset_n = 1'b1;
        tick(1);
        access(1'b0, A_KEY, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (a1 !== 1'b1 || r1 !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL reset_key_read: got ack=%b rdata=%h required 1/0000000f", a1, r1);
        end
        access(1'b0, A_KEDGE, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (a1 !== 1'b1 || r1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_kedge_read: got ack=%b rdata=%h required 1/0", a1, r1);
        end
    endtask

    task automatic test_hex;
        logic a1, a2;
        logic [31:0] r1, r2;
        access(1'b1, A_HEX, 32'h1234ABCD, a1, r1, a2, r2);
        m_hex = 16'hABCD;
        n_tests++;
        if (a1 !== 1'b1 || a2 !== 1'b0 || r2 !== 32'h0) begin
            n_fail++;
            $display("FAIL hex_write_ack: got ack N+1=%b N+2=%b rdata N+2=%h required 1/0/0", a1, a2, r2);
        end
        n_tests++;
        if (HEX_VAL !== 16'hABCD) begin
            n_fail++;
            $display("FAIL hex_port: got %h required abcd", HEX_VAL);
        end
        access(1'b0, A_HEX, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (a1 !== 1'b1 || r1 !== 32'h0000ABCD) begin
            n_fail++;
            $display("FAIL hex_readback: got ack=%b rdata=%h required 1/0000abcd", a1, r1);
        end
    endtask

    task automatic test_random;
        logic a1, a2;
        logic [31:0] r1, r2, d, exp;
        logic [31:0] tbl [9];
        logic w;
        int k;
        tbl = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_KEDGE, A_SW,
                32'hFFFF0200, 32'hFFFF0004, 32'hFFFF0FFC};
        for (int it = 0; it < 40; it++) begin
            SWITCH = 10'($urandom);
            tick(2);
            k = $urandom_range(0, 8);
            w = 1'($urandom);
            d = $urandom;
            case (k)
                0: exp = {16'b0, m_hex};
                1: exp = {22'b0, m_ledr};
                2: exp = {24'b0, m_ledg};
                3: exp = 32'hF;
                5: exp = {22'b0, SWITCH};
                default: exp = 32'h0;
            endcase
            access(w, tbl[k], d, a1, r1, a2, r2);
            if (w) begin
                if (k == 0) m_hex  = d[15:0];
                if (k == 1) m_ledr = d[9:0];
                if (k == 2) m_ledg = d[7:0];
            end
            n_tests++;
            if (a1 !== 1'b1 || a2 !== 1'b0 || r2 !== 32'h0) begin
                n_fail++;
                $display("FAIL rand_ack it=%0d: got ack=%b/%b rdata_after=%h required 1/0/0", it, a1, a2, r2);
            end
            if (!w) begin
                n_tests++;
                if (r1 !== exp) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d addr=%h: got %h required %h", it, tbl[k], r1, exp);
                end
            end
            n_tests++;
            if (HEX_VAL !== m_hex || LEDR !== m_ledr || LEDG !== m_ledg) begin
                n_fail++;
                $display("FAIL rand_ports it=%0d: got %h/%h/%h required %h/%h/%h",
                         it, HEX_VAL, LEDR, LEDG, m_hex, m_ledr, m_ledg);
            end
        end
    endtask

    task automatic test_debounce;
        logic a1, a2;
        logic [31:0] r1, r2, exp;
        for (int off = 5; off <= 6; off++) begin
            KEY = 4'hF;
            tick(12);
            access(1'b1, A_KEDGE, 32'hF, a1, r1, a2, r2);
            KEY[1] = 1'b0; tick(2);
            KEY[1] = 1'b1; tick(2);
            KEY[1] = 1'b0; tick(2);
            KEY[1] = 1'b1; tick(2);
            KEY[1] = 1'b0;
            tick(off);
            exp = (off < 6) ? 32'hF : 32'hD;
            access(1'b0, A_KEY, 32'h0, a1, r1, a2, r2);
            n_tests++;
            if (r1 !== exp) begin
                n_fail++;
                $display("FAIL debounce_key off=%0d: got %h required %h", off, r1, exp);
            end
            access(1'b0, A_KEDGE, 32'h0, a1, r1, a2, r2);
            n_tests++;
            if (r1 !== 32'h2) begin
                n_fail++;
                $display("FAIL debounce_edge off=%0d: got %h required 00000002", off, r1);
            end
        end
        access(1'b1, A_KEDGE, 32'h2, a1, r1, a2, r2);
        access(1'b0, A_KEDGE, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (r1 !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear: got %h required 0", r1);
        end
    endtask

    task automatic test_w1c_collision;
        logic a1, a2;
        logic [31:0] r1, r2;
        KEY = 4'hF;
        tick(12);
        access(1'b1, A_KEDGE, 32'hF, a1, r1, a2, r2);
        KEY[0] = 1'b0;
        tick(5);
        access(1'b1, A_KEDGE, 32'h1, a1, r1, a2, r2);
        access(1'b0, A_KEDGE, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (r1 !== 32'h1) begin
            n_fail++;
            $display("FAIL set_wins: got %h required 00000001", r1);
        end
        access(1'b0, A_KEY, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (r1 !== 32'hE) begin
            n_fail++;
            $display("FAIL key_pressed: got %h required 0000000e", r1);
        end
        access(1'b1, A_KEDGE, 32'h1, a1, r1, a2, r2);
        access(1'b0, A_KEDGE, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (r1 !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_after_set: got %h required 0", r1);
        end
        KEY = 4'hF;
        tick(12);
    endtask

    task automatic test_unmapped;
        logic a1, a2;
        logic [31:0] r1, r2;
        access(1'b1, 32'hFFFF0200, 32'hFFFFFFFF, a1, r1, a2, r2);
        access(1'b0, 32'hFFFF0200, 32'h0, a1, r1, a2, r2);
        n_tests++;
        if (a1 !== 1'b1 || r1 !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got ack=%b rdata=%h required 1/0", a1, r1);
        end
        n_tests++;
        if (HEX_VAL !== m_hex || LEDR !== m_ledr || LEDG !== m_ledg) begin
            n_fail++;
            $display("FAIL unmapped_write: got %h/%h/%h required %h/%h/%h",
                     HEX_VAL, LEDR, LEDG, m_hex, m_ledr, m_ledg);
        end
        addr = 32'hFFFF0FFC;
        #1;
        n_tests++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_top: got %b required 1", hit);
        end
        addr = 32'hFFFF1000;
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_above: got %b required 0", hit);
        end
        req = 1'b1; we = 1'b1; addr = 32'h00000020; wdata = 32'h3FF;
        #1;
        n_tests++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_low: got %b required 0", hit);
        end
        tick(1);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        n_tests++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_ack: got %b required 0", ack);
        end
        tick(1);
        n_tests++;
        if (ack !== 1'b0 || LEDR !== m_ledr) begin
            n_fail++;
            $display("FAIL miss_nochange: got ack=%b ledr=%h required 0/%h", ack, LEDR, m_ledr);
        end
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        req = 1'b1; we = 1'b0; addr = A_LEDR;
        tick(1);
        if (ack === 1'b1) acks++;
        we = 1'b1; addr = A_LEDG; wdata = {24'b0, ~m_ledg};
        tick(1);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (ack === 1'b1) acks++;
            tick(1);
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL back_to_back_acks: got %0d required 1", acks);
        end
        n_tests++;
        if (LEDG !== m_ledg) begin
            n_fail++;
            $display("FAIL back_to_back_drop: got ledg=%h required %h", LEDG, m_ledg);
        end
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        req = 1'b1; we = 1'b1; addr = A_LEDR; wdata = 32'h2AA;
        @(posedge clk);
        reset_n = 1'b0;
        #1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        if (ack === 1'b1) acks++;
        tick(1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (ack === 1'b1) acks++;
            tick(1);
        end
        m_hex = '0; m_ledr = '0; m_ledg = '0;
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ack: got %0d acks required 0", acks);
        end
        n_tests++;
        if (LEDR !== 10'd0 || HEX_VAL !== 16'd0 || LEDG !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_regs: got ledr=%h hex=%h ledg=%h required 0", LEDR, HEX_VAL, LEDG);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_random();
        test_debounce();
        test_w1c_collision();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
